dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU load/store path (port 0) and a debug/loader master (port 1).
//  Sequences each access: arbitrate, drive the memory command for MEM_LAT cycles, capture read data, return a one-cycle ack.
//  Sits between the CPU's Data_Memory interface and the memory; the CPU treats cpu_stall_o as a PC/pipeline hold.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  1   memory access cycles per transfer (legal 1..15)
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   asynchronous reset, active-low
//  cpu_req_i    in   1   port 0 request; held high until cpu_ack_o seen
//  cpu_we_i     in   1   port 0 write (1) / read (0)
//  cpu_addr_i   in   AW  port 0 address
//  cpu_wdata_i  in   DW  port 0 write data
//  cpu_ack_o    out  1   port 0 transfer complete, one-cycle pulse
//  cpu_rdata_o  out  DW  port 0 read data, valid while cpu_ack_o=1
//  cpu_stall_o  out  1   cpu_req_i & ~cpu_ack_o (combinational)
//  dbg_req_i / dbg_we_i / dbg_addr_i / dbg_wdata_i  in   1/1/AW/DW  port 1, same rules as port 0
//  dbg_ack_o / dbg_rdata_o                          out  1/DW       port 1, same rules as port 0
//  mem_addr_o   out  AW  memory address (latched at grant)
//  mem_wdata_o  out  DW  memory write data (latched at grant)
//  mem_read_o   out  1   read strobe
//  mem_write_o  out  1   write strobe
//  mem_rdata_i  in   DW  memory read data, sampled in the last ACCESS cycle
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, cnt=0, last_gnt=1; every output 0 immediately.
//  FSM: IDLE -> ACCESS -> ACK -> IDLE.
//   IDLE: if any req, pick winner, latch addr/wdata/we/owner, cnt<=MEM_LAT-1, go ACCESS. Else stay.
//   ACCESS: mem_read_o=~we for all cycles; mem_write_o=we only when cnt==0. cnt decrements.
//           At cnt==0: rdata_q<=mem_rdata_i (reads only), go ACK.
//   ACK: owner's ack_o=1 and rdata_o=rdata_q; last_gnt<=owner; go IDLE unconditionally.
//  Latency: req high at edge k in IDLE -> ACCESS cycles k+1..k+MEM_LAT -> ack in cycle k+MEM_LAT+1.
//  Throughput: one transfer per MEM_LAT+2 cycles (mandatory IDLE bubble).
//  Arbitration (default): round-robin.
//   Both requesting -> grant port != last_gnt.
//   Single requester -> granted regardless of last_gnt.
//   First tie after reset goes to port 0.
//  Non-owner request arriving during ACCESS/ACK waits; it is not dropped.
//  Requester deasserting req mid-transfer: the transfer still completes and acks (ack is ignored by the requester).
//  rdata_o holds the last captured value when ack_o=0; write transfers leave rdata_q unchanged.
//  Only one of cpu_ack_o/dbg_ack_o is ever high; mem_read_o and mem_write_o are never both high.
//  Reset during ACCESS: strobes drop asynchronously, no ack is issued, and the transfer is lost.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: port 0 (CPU) always wins a tie; last_gnt is unused; port 1 may starve.
//  ARB_FIXED_PRIO_EN undefined: round-robin as above.
// TESTING
//  MEM_LAT=1, CPU read 0x10, mem returns 0xDEADBEEF -> mem_read_o high 1 cycle, cpu_ack_o next cycle with 0xDEADBEEF.
//  MEM_LAT=3, dbg write 0x20<-0x12345678 -> read strobe 0, mem_write_o only in 3rd ACCESS cycle, dbg_ack_o in cycle 4.
//  Both req same cycle after reset, then both re-req -> grant order cpu, dbg, cpu; ack spacing MEM_LAT+2 cycles.
//  Same as previous with ARB_FIXED_PRIO_EN -> cpu, cpu, cpu while cpu keeps requesting; dbg stalls.
//  rst_i=0 in middle ACCESS cycle (MEM_LAT=3) -> strobes and acks 0 at once; after release, IDLE and re-req acked normally.
//  CPU read then write -> cpu_rdata_o holds the read value after the write ack; cpu_stall_o=req&~ack each cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between CPU (port 0) and debug (port 1); ARB_FIXED_PRIO_EN selects fixed CPU priority
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  input  logic [DW-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic owner, last_gnt, we_q, pick;
  logic [DW-1:0] rdata_q;
`ifdef ARB_FIXED_PRIO_EN
  assign pick = ~cpu_req_i;
`else
  assign pick = (cpu_req_i & dbg_req_i) ? ~last_gnt : dbg_req_i;
`endif
  assign cpu_rdata_o = rdata_q;
  assign dbg_rdata_o = rdata_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= next;
  // next state and strobes/acks decoded from the current state
  always_comb begin
    next = state;
    mem_read_o = 1'b0;
    mem_write_o = 1'b0;
    cpu_ack_o = 1'b0;
    dbg_ack_o = 1'b0;
    case (state)
      IDLE: next = (cpu_req_i | dbg_req_i) ? ACCESS : IDLE;
      ACCESS: begin
        mem_read_o = ~we_q;
        mem_write_o = we_q & (cnt == 4'd0);
        next = (cnt == 4'd0) ? ACK : ACCESS;
      end
      ACK: begin
        cpu_ack_o = ~owner;
        dbg_ack_o = owner;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  // grant latching, access countdown, read capture and round-robin history
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt <= 4'd0;
      last_gnt <= 1'b1;
      owner <= 1'b0;
      we_q <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      rdata_q <= '0;
    end else if (state == IDLE && (cpu_req_i | dbg_req_i)) begin
      owner <= pick;
      we_q <= pick ? dbg_we_i : cpu_we_i;
      mem_addr_o <= pick ? dbg_addr_i : cpu_addr_i;
      mem_wdata_o <= pick ? dbg_wdata_i : cpu_wdata_i;
      cnt <= 4'(MEM_LAT - 1);
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else if (!we_q) rdata_q <= mem_rdata_i;
    end else if (state == ACK)
      last_gnt <= owner;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random checks of dmem_port_arbiter against a transaction-timeline model
module tb_dmem_port_arbiter;
  localparam int LAT = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0, mem_rdata = 0;
  logic cpu_ack_o, cpu_stall_o, dbg_ack_o, mem_read_o, mem_write_o;
  logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o;
  int n_chk = 0, n_fail = 0;
  // model: grant edge g, transfer occupies LAT access periods then one ack period
  int e, g;
  bit busy, own, lg, m_we, ack_c, ack_d;
  logic [31:0] m_addr, m_wdata, rq;

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; lg = 1; rq = 0; e = 0; g = 0; own = 0; m_we = 0;
  endtask

  task automatic model_step();
    if (!rst_n) return;
    e++;
    if (busy && e == g + LAT && !m_we) rq = mem_rdata;
    if (busy && e == g + LAT + 1) begin
      busy = 0;
      lg = own;
    end else if (!busy && (cpu_req || dbg_req)) begin
`ifdef ARB_FIXED_PRIO_EN
      own = !cpu_req;
`else
      own = (cpu_req && dbg_req) ? !lg : dbg_req;
`endif
      m_we = own ? dbg_we : cpu_we;
      m_addr = own ? dbg_addr : cpu_addr;
      m_wdata = own ? dbg_wdata : cpu_wdata;
      g = e;
      busy = 1;
    end
  endtask

  task automatic compare();
    int off;
    bit acc, ackp;
    off = e - g;
    acc = busy && off < LAT;
    ackp = busy && off == LAT;
    ack_c = ackp && !own;
    ack_d = ackp && own;
    chk("mem_read", mem_read_o, acc && !m_we);
    chk("mem_write", mem_write_o, acc && m_we && off == LAT - 1);
    chk("cpu_ack", cpu_ack_o, ack_c);
    chk("dbg_ack", dbg_ack_o, ack_d);
    chk("cpu_stall", cpu_stall_o, cpu_req && !ack_c);
    if (acc) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    if (ack_c) chk("cpu_rdata", cpu_rdata_o, rq);
    if (ack_d) chk("dbg_rdata", dbg_rdata_o, rq);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) step();
    rst_n = 1;
  endtask

  int lat, nr, ws, nacks;
  int ack_at[3];
  bit ack_who[3];
  logic [31:0] rd, wa, wd;
  bit rd_before;

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_read", mem_read_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_cpu_ack", cpu_ack_o, 0);
    chk("rst_dbg_ack", dbg_ack_o, 0);
    chk("rst_rdata", cpu_rdata_o, 0);
    do_reset();
    // CPU read 0x10 returning DEADBEEF
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    lat = 0; nr = 0; rd = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (mem_read_o) nr++;
      if (cpu_ack_o) begin lat = i; rd = cpu_rdata_o; break; end
    end
    cpu_req = 0;
    chk("rd_strobe_cycles", nr, LAT);
    chk("rd_latency", lat, LAT + 1);
    chk("rd_data", rd, 32'hDEADBEEF);
    step();
    // debug write 0x20 <- 12345678
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; mem_rdata = 32'h0BADF00D;
    lat = 0; nr = 0; ws = 0; wa = 0; wd = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (mem_read_o) nr++;
      if (mem_write_o) begin ws = i; wa = mem_addr_o; wd = mem_wdata_o; end
      if (dbg_ack_o) begin lat = i; break; end
    end
    dbg_req = 0;
    chk("wr_read_strobes", nr, 0);
    chk("wr_strobe_cycle", ws, LAT);
    chk("wr_addr", wa, 32'h20);
    chk("wr_data", wd, 32'h12345678);
    chk("wr_latency", lat, LAT + 1);
    chk("rdata_hold_after_write", cpu_rdata_o, 32'hDEADBEEF);
    step();
    // simultaneous requests after reset
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
    nacks = 0;
    for (int i = 1; i <= 40 && nacks < 3; i++) begin
      step();
      if (cpu_ack_o || dbg_ack_o) begin
        ack_at[nacks] = i;
        ack_who[nacks] = dbg_ack_o;
        nacks++;
      end
    end
    cpu_req = 0; dbg_req = 0;
    chk("tie_ack_count", nacks, 3);
    chk("tie_grant0", ack_who[0], 0);
`ifdef ARB_FIXED_PRIO_EN
    chk("tie_grant1", ack_who[1], 0);
`else
    chk("tie_grant1", ack_who[1], 1);
`endif
    chk("tie_grant2", ack_who[2], 0);
    chk("tie_spacing1", ack_at[1] - ack_at[0], LAT + 2);
    chk("tie_spacing2", ack_at[2] - ack_at[1], LAT + 2);
    repeat (3) step();
    // reset in the middle access cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
    repeat (2) step();
    rd_before = mem_read_o;
    rst_n = 0;
    #1;
    chk("mid_rst_strobe_before", rd_before, 1);
    chk("mid_rst_read", mem_read_o, 0);
    chk("mid_rst_ack", cpu_ack_o, 0);
    model_reset();
    step();
    rst_n = 1;
    lat = 0; rd = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cpu_ack_o) begin lat = i; rd = cpu_rdata_o; break; end
    end
    cpu_req = 0;
    chk("post_rst_latency", lat, LAT + 1);
    chk("post_rst_data", rd, 32'hCAFEF00D);
    step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (cpu_req) begin
        if (ack_c || $urandom_range(0, 19) == 0) cpu_req = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (dbg_req) begin
        if (ack_d || $urandom_range(0, 19) == 0) dbg_req = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = $urandom; dbg_wdata = $urandom;
      end
      mem_rdata = $urandom;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
